// File: rtl/progetto_labdig_if.sv
// Register bus between a host and progetto_labdig.
// Zero-wait-state: the slave answers ready/rdata/error in the same cycle as valid.
interface reg_bus #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error;

  modport in  (input addr, write, wdata, wstrb, valid, output rdata, ready, error);
  modport out (output addr, write, wdata, wstrb, valid, input rdata, ready, error);
endinterface

// File: rtl/progetto_labdig.sv
// Bit-flip scrub monitor: measures cycles between scrub events, the flip density of
// each event, and raises interr_o when events come too close together.
// Optional macro PROGETTO_LABDIG_INTERR_CLEAR_EN enables write-one-to-clear of the interrupt.
module progetto_labdig #(
  parameter int unsigned INTERR_THRESHOLD = 100,
  parameter int unsigned IN_DATA_WIDTH    = 100
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [IN_DATA_WIDTH-1:0] scrub_i,
  reg_bus.in                       bus_if,
  output logic                     interr_o
);

  logic [31:0] cnt_q;
  logic        armed_q;
  logic        interr_q;
  logic [31:0] cyclesxbf_q;
  logic [31:0] bfdensity_q;

  logic        scrub_event;
  logic [31:0] popcount;
  logic        clear_req;
  logic        write_reject;

  assign scrub_event = |scrub_i;

  always_comb begin
    popcount = '0;
    for (int i = 0; i < int'(IN_DATA_WIDTH); i++) begin
      popcount = popcount + 32'(scrub_i[i]);
    end
  end

`ifdef PROGETTO_LABDIG_INTERR_CLEAR_EN
  logic unused_wbits;
  assign unused_wbits = ^{bus_if.wdata[31:1], bus_if.wstrb[3:1]};
  assign clear_req    = bus_if.valid & bus_if.write & (bus_if.addr == 2'd0) &
                        bus_if.wstrb[0] & bus_if.wdata[0];
  assign write_reject = (bus_if.addr != 2'd0);
`else
  logic unused_wbits;
  assign unused_wbits = ^{bus_if.wdata, bus_if.wstrb};
  assign clear_req    = 1'b0;
  assign write_reject = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      interr_q    <= 1'b0;
      cyclesxbf_q <= '0;
      bfdensity_q <= '0;
    end else begin
      if (scrub_event) begin
        cnt_q       <= 32'd1;
        armed_q     <= 1'b1;
        bfdensity_q <= popcount;
        if (armed_q) begin
          cyclesxbf_q <= cnt_q;
          interr_q    <= (cnt_q < INTERR_THRESHOLD);
        end else if (clear_req) begin
          interr_q <= 1'b0;
        end
      end else begin
        if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
        // An armed event above wins over a simultaneous clear.
        if (clear_req) interr_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus_if.rdata = '0;
    case (bus_if.addr)
      2'd0:    bus_if.rdata = {31'b0, interr_q};
      2'd1:    bus_if.rdata = cyclesxbf_q;
      2'd2:    bus_if.rdata = bfdensity_q;
      default: bus_if.rdata = '0;
    endcase
  end

  assign bus_if.ready = bus_if.valid;
  assign bus_if.error = bus_if.valid & bus_if.write & write_reject;
  assign interr_o     = interr_q;

endmodule

// File: tb/tb_progetto_labdig.sv
// Directed bench for progetto_labdig: interval capture, threshold edges, density,
// reset behaviour and write handling (both builds of PROGETTO_LABDIG_INTERR_CLEAR_EN).
module tb_progetto_labdig;

  localparam int W = 100;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [W-1:0] scrub_i;
  logic         interr_o;

  int checks   = 0;
  int failures = 0;

  reg_bus #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

  progetto_labdig #(.INTERR_THRESHOLD(100), .IN_DATA_WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .scrub_i  (scrub_i),
    .bus_if   (bus),
    .interr_o (interr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp_v);
    bus.addr  = a;
    bus.write = 1'b0;
    bus.valid = 1'b1;
    #1;
    chk(tag, bus.rdata, exp_v);
    chk({tag, "_ready"}, {31'b0, bus.ready}, 32'd1);
    chk({tag, "_err"}, {31'b0, bus.error}, 32'd0);
    bus.valid = 1'b0;
  endtask

  // Next event lands exactly gap edges after the previous event edge.
  task automatic event_after(input int gap, input logic [W-1:0] pat);
    scrub_i = '0;
    repeat (gap - 1) tick();
    scrub_i = pat;
    tick();
    scrub_i = '0;
  endtask

  logic [W-1:0] one_bit;
  logic [W-1:0] five_bits;

  initial begin
    one_bit   = '0;
    one_bit[0] = 1'b1;
    five_bits = '0;
    five_bits[0]  = 1'b1;
    five_bits[3]  = 1'b1;
    five_bits[50] = 1'b1;
    five_bits[98] = 1'b1;
    five_bits[99] = 1'b1;

    rstn_i    = 1'b0;
    scrub_i   = '0;
    bus.addr  = '0;
    bus.write = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.valid = 1'b0;

    repeat (3) tick();
    chk("rst_interr_o", {31'b0, interr_o}, 32'd0);
    rstn_i = 1'b1;
    tick();
    rd(2'd0, "rst_a0", 32'd0);
    rd(2'd1, "rst_a1", 32'd0);
    rd(2'd2, "rst_a2", 32'd0);
    rd(2'd3, "rst_a3", 32'd0);
    #1;
    chk("ready_idle", {31'b0, bus.ready}, 32'd0);

    // First event only arms.
    scrub_i = one_bit;
    tick();
    scrub_i = '0;
    chk("arm_interr_o", {31'b0, interr_o}, 32'd0);
    rd(2'd1, "arm_a1", 32'd0);
    rd(2'd2, "arm_a2", 32'd1);

    event_after(99, one_bit);
    chk("i99_interr_o", {31'b0, interr_o}, 32'd1);
    rd(2'd0, "i99_a0", 32'd1);
    rd(2'd1, "i99_a1", 32'h63);

    event_after(100, one_bit);
    chk("i100_interr_o", {31'b0, interr_o}, 32'd0);
    rd(2'd1, "i100_a1", 32'h64);

    event_after(97, one_bit);
    chk("i97_interr_o", {31'b0, interr_o}, 32'd1);
    rd(2'd1, "i97_a1", 32'h61);

    event_after(10, five_bits);
    rd(2'd2, "d5_a2", 32'd5);
    rd(2'd1, "d5_a1", 32'd10);
    repeat (3) tick();
    rd(2'd2, "hold_a2", 32'd5);
    rd(2'd1, "hold_a1", 32'd10);
    chk("hold_interr_o", {31'b0, interr_o}, 32'd1);

    // Write-one-to-clear attempt on addr 0.
    bus.addr  = 2'd0;
    bus.write = 1'b1;
    bus.wdata = 32'd1;
    bus.wstrb = 4'hF;
    bus.valid = 1'b1;
    #1;
    chk("w0_ready", {31'b0, bus.ready}, 32'd1);
`ifdef PROGETTO_LABDIG_INTERR_CLEAR_EN
    chk("w0_err", {31'b0, bus.error}, 32'd0);
    tick();
    bus.valid = 1'b0;
    chk("w0_interr_o", {31'b0, interr_o}, 32'd0);
`else
    chk("w0_err", {31'b0, bus.error}, 32'd1);
    tick();
    bus.valid = 1'b0;
    chk("w0_interr_o", {31'b0, interr_o}, 32'd1);
`endif
    bus.addr  = 2'd2;
    bus.valid = 1'b1;
    #1;
    chk("w2_err", {31'b0, bus.error}, 32'd1);
    tick();
    bus.valid = 1'b0;
    bus.write = 1'b0;
    rd(2'd2, "w2_a2", 32'd5);

    // Armed event coinciding with a clear write: event wins (interval 7 < 100).
    tick();
    scrub_i   = one_bit;
    bus.addr  = 2'd0;
    bus.write = 1'b1;
    bus.wdata = 32'd1;
    bus.wstrb = 4'h1;
    bus.valid = 1'b1;
    tick();
    scrub_i   = '0;
    bus.valid = 1'b0;
    bus.write = 1'b0;
    chk("prio_interr_o", {31'b0, interr_o}, 32'd1);
    rd(2'd1, "prio_a1", 32'd7);

    // Reset mid-interval discards state and disarms.
    repeat (5) tick();
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_interr_o", {31'b0, interr_o}, 32'd0);
    rd(2'd1, "mid_rst_a1", 32'd0);
    rd(2'd2, "mid_rst_a2", 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();
    scrub_i = five_bits;
    tick();
    scrub_i = '0;
    chk("rearm_interr_o", {31'b0, interr_o}, 32'd0);
    rd(2'd1, "rearm_a1", 32'd0);
    rd(2'd2, "rearm_a2", 32'd5);
    event_after(5, one_bit);
    rd(2'd1, "i5_a1", 32'd5);
    rd(2'd2, "i5_a2", 32'd1);
    chk("i5_interr_o", {31'b0, interr_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/progetto_labdig.md
PROGETTO_LABDIG -- requirements
Module: progetto_labdig

Interface
REQ-001 SHALL have parameter INTERR_THRESHOLD, default 100: an interval strictly below this many cycles flags an interrupt.
REQ-002 SHALL have parameter IN_DATA_WIDTH, default 100: width of the scrub vector, range 1..127.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state is on the rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port scrub_i, input, IN_DATA_WIDTH bits: per-bit bit-flip indications, sampled every cycle.
REQ-006 SHALL have port bus_if, REG_BUS slave modport "in", ADDR_WIDTH=2, DATA_WIDTH=32, with these fields:
- addr[1:0], write, wdata[31:0], wstrb[3:0] and valid are inputs.
- rdata[31:0], ready and error are outputs.
REQ-007 SHALL have port interr_o, output, 1 bit: interrupt flag, equal to register 0 bit 0.

Function
REQ-008 SHALL treat a cycle as an event when at least one bit of scrub_i is 1 at a rising edge.
REQ-009 SHALL keep a 32-bit counter cnt_q with this per-edge behaviour:
- On an event, cnt_q loads 1.
- Otherwise cnt_q increments by 1 and saturates at 0xFFFFFFFF.
REQ-010 SHALL keep an armed_q flag that is set on the first event after reset; the first event captures no interval.
REQ-011 SHALL, on each event with armed_q=1, capture the interval cyclesxbf_q <= cnt_q; events k rising edges apart give cyclesxbf_q = k.
REQ-012 SHALL, on each event with armed_q=1, update interr_q <= (cnt_q < INTERR_THRESHOLD); the interrupt therefore both sets and clears on events.
REQ-013 SHALL leave interr_q and cyclesxbf_q unchanged on events with armed_q=0 and on non-event cycles.
REQ-014 SHALL, on every event, load bfdensity_q with the population count of scrub_i, zero-extended to 32 bits; it holds between events.
REQ-015 SHALL decode the register map as follows:
- addr 0 reads {31'b0, interr_q}.
- addr 1 reads cyclesxbf_q.
- addr 2 reads bfdensity_q.
- addr 3 reads 0.
REQ-016 SHALL drive ready = valid combinationally: zero-wait-state, single-cycle handshake, no back-pressure.
REQ-017 SHALL drive rdata combinationally from addr, regardless of valid.
REQ-018 SHALL drive error = valid & write & (write not accepted per REQ-022/REQ-023); reads never error.
REQ-019 SHALL drive interr_o = interr_q, a registered output with no extra latency.
REQ-020 SHALL make register contents reflect an event one cycle after the event edge, i.e. from the next cycle onwards.

Reset
REQ-021 SHALL, while rstn_i=0, asynchronously clear cnt_q, armed_q, interr_q, cyclesxbf_q and bfdensity_q to 0, so interr_o=0; reset asserted mid-interval discards the pending interval.

Configuration
REQ-022 SHALL, when macro PROGETTO_LABDIG_INTERR_CLEAR_EN is defined, implement write-one-to-clear of the interrupt:
- A write (valid & write) to addr 0 with wstrb[0]=1 and wdata[0]=1 clears interr_q and gives error=0.
- An armed event in the same cycle takes priority over the clear.
- Writes to addr 1..3 give error=1 and have no effect.
REQ-023 SHALL, when PROGETTO_LABDIG_INTERR_CLEAR_EN is undefined, ignore all writes and give error=1 on any write.

Verification
REQ-024 SHALL pass this scenario: after reset, read addr 0/1/2/3 -> rdata 0 for all, interr_o=0, ready=1 in the same cycle as valid.
REQ-025 SHALL pass this scenario: scrub_i=1 at edge t, then 0 for 98 cycles, then 1 at edge t+99 -> interr_o=1, addr 0 reads 0x00000001, addr 1 reads 0x00000063.
REQ-026 SHALL pass this scenario: events 100 edges apart -> interr_o=0 and addr 1 reads 0x00000064.
REQ-027 SHALL pass this scenario: events 97 edges apart -> addr 1 reads 0x00000061 and interr_o=1.
REQ-028 SHALL pass this scenario: scrub_i with 5 bits set, then 0 -> addr 2 reads 0x00000005; a single-bit event after reset leaves interr_o=0 (not armed).
REQ-029 SHALL pass this scenario (macro defined): with interr_o=1, write addr 0 with wdata=1, wstrb=0xF -> interr_o=0 next cycle, error=0; write to addr 2 -> error=1.
